// File: rtl/crypto_pkg.sv
// Shared definitions for the ENCRY crypto sequencer and the control unit that drives it.
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROUND  = 2'd2,
    FINISH = 2'd3
  } crypto_state_t;

  localparam logic [6:0] OP_ENCRY = 7'b1111111;
  localparam logic [2:0] F3_ENC   = 3'b000;
  localparam logic [2:0] F3_DEC   = 3'b001;

endpackage

// File: rtl/crypto_round_seq_if.sv
// Handshake and datapath-control bundle between the CU (master) and the round sequencer (slave).
interface crypto_round_seq_if #(
  parameter int ROUND_W = 2
);

  logic               CRY_START;
  logic [2:0]         CRY_FUNC3;
  logic               CRY_ABORT;
  logic               CRY_BUSY;
  logic               CRY_DONE;
  logic               CRY_ILLEGAL;
  logic               CRY_LOAD;
  logic               CRY_ROUND_EN;
  logic [ROUND_W-1:0] CRY_ROUND;
  logic [ROUND_W-1:0] CRY_KEY_SEL;
  logic               CRY_RESULT_WE;

  modport master (
    output CRY_START, CRY_FUNC3, CRY_ABORT,
    input  CRY_BUSY, CRY_DONE, CRY_ILLEGAL, CRY_LOAD, CRY_ROUND_EN,
           CRY_ROUND, CRY_KEY_SEL, CRY_RESULT_WE
  );

  modport slave (
    input  CRY_START, CRY_FUNC3, CRY_ABORT,
    output CRY_BUSY, CRY_DONE, CRY_ILLEGAL, CRY_LOAD, CRY_ROUND_EN,
           CRY_ROUND, CRY_KEY_SEL, CRY_RESULT_WE
  );

endinterface

// File: rtl/crypto_round_seq.sv
// Start/busy/done sequencer for the ENCRY round datapath: load, ROUNDS round steps, result write.
// All outputs are Moore-decoded from the registered state, round counter, mode bit and illegal flag.
module crypto_round_seq
  import crypto_pkg::*;
#(
  parameter int ROUNDS  = 4,
  parameter int ROUND_W = 2
) (
  input  logic                CRY_CLK,
  input  logic                CRY_RESET,
  crypto_round_seq_if.slave   cry
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  crypto_state_t      state;
  logic [ROUND_W-1:0] counter;
  logic               mode;
  logic               illegal_pulse;
  logic               func3_legal;
  logic               in_round;

  assign func3_legal = (cry.CRY_FUNC3 == F3_ENC) || (cry.CRY_FUNC3 == F3_DEC);

  // Abort overrides everything, including a START seen in the same IDLE cycle.
  always_ff @(posedge CRY_CLK or posedge CRY_RESET) begin
    if (CRY_RESET) begin
      state         <= IDLE;
      counter       <= '0;
      mode          <= 1'b0;
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= 1'b0;
      if (cry.CRY_ABORT) begin
        state   <= IDLE;
        counter <= '0;
        mode    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cry.CRY_START) begin
              if (func3_legal) begin
                state   <= LOAD;
                counter <= '0;
                mode    <= (cry.CRY_FUNC3 == F3_DEC);
              end else begin
                illegal_pulse <= 1'b1;
              end
            end
          end
          LOAD: state <= ROUND;
          ROUND: begin
            // Terminal compare instead of wrap, so ROUNDS == 2**ROUND_W still works.
            if (counter == LAST_ROUND) begin
              state <= FINISH;
            end else begin
              counter <= counter + ROUND_W'(1);
            end
          end
          FINISH: begin
            state   <= IDLE;
            counter <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign in_round = (state == ROUND);

  assign cry.CRY_BUSY      = (state != IDLE);
  assign cry.CRY_DONE      = (state == FINISH) || illegal_pulse;
  assign cry.CRY_ILLEGAL   = illegal_pulse;
  assign cry.CRY_LOAD      = (state == LOAD);
  assign cry.CRY_ROUND_EN  = in_round;
  assign cry.CRY_RESULT_WE = (state == FINISH);
  assign cry.CRY_ROUND     = in_round ? counter : '0;
  // Decrypt walks the key schedule backwards.
  assign cry.CRY_KEY_SEL   = !in_round ? '0 : (mode ? (LAST_ROUND - counter) : counter);

endmodule

// File: tb/tb_crypto_round_seq.sv
// Directed self-checking bench for crypto_round_seq with the default ROUNDS=4, ROUND_W=2.
module tb_crypto_round_seq;
  import crypto_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   done_seen;

  crypto_round_seq_if #(.ROUND_W(2)) cry ();

  crypto_round_seq #(.ROUNDS(4), .ROUND_W(2)) dut (
    .CRY_CLK   (clk),
    .CRY_RESET (rst),
    .cry       (cry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every DONE pulse is tallied so the total can be matched against accepted/illegal STARTs.
  always @(negedge clk) begin
    if (cry.CRY_DONE === 1'b1) done_seen++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] pack(input logic busy, input logic done, input logic ill,
                                      input logic load, input logic ren, input logic we,
                                      input logic [1:0] rnd, input logic [1:0] key);
    return {busy, done, ill, load, ren, we, rnd, key};
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    logic [9:0] observed;
    observed = {cry.CRY_BUSY, cry.CRY_DONE, cry.CRY_ILLEGAL, cry.CRY_LOAD, cry.CRY_ROUND_EN,
                cry.CRY_RESULT_WE, cry.CRY_ROUND, cry.CRY_KEY_SEL};
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%b expected=%b (busy,done,ill,load,ren,we,round,key)",
               tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic start, input logic [2:0] f3, input logic abort);
    cry.CRY_START = start;
    cry.CRY_FUNC3 = f3;
    cry.CRY_ABORT = abort;
  endtask

  // Full legal operation starting from IDLE at a negedge; keys are the hand-derived schedule.
  task automatic runOp(input logic [2:0] f3, input logic [1:0] k0, input logic [1:0] k1,
                       input logic [1:0] k2, input logic [1:0] k3, input string tag);
    logic [1:0] keys [4];
    keys[0] = k0; keys[1] = k1; keys[2] = k2; keys[3] = k3;
    applyStimulus(1'b1, f3, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput({tag, "_load"}, pack(1, 0, 0, 1, 0, 0, 2'd0, 2'd0));
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_round%0d", tag, r), pack(1, 0, 0, 0, 1, 0, 2'(r), keys[r]));
    end
    @(negedge clk);
    checkOutput({tag, "_finish"}, pack(1, 1, 0, 0, 0, 1, 2'd0, 2'd0));
    @(negedge clk);
    checkOutput({tag, "_idle"}, pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b0);
    #2;
    checkOutput("reset", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));

    // Encrypt followed immediately by decrypt at the minimum issue interval.
    runOp(F3_ENC, 2'd0, 2'd1, 2'd2, 2'd3, "enc");
    runOp(F3_DEC, 2'd3, 2'd2, 2'd1, 2'd0, "dec");

    // Illegal func3 answers with a lone ILLEGAL+DONE pulse and never goes busy.
    applyStimulus(1'b1, 3'b010, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput("illegal_pulse", pack(0, 1, 1, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    checkOutput("illegal_clear", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));

    // Abort during round 2.
    applyStimulus(1'b1, F3_DEC, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput("abort_load", pack(1, 0, 0, 1, 0, 0, 2'd0, 2'd0));
    repeat (3) @(negedge clk);
    checkOutput("abort_round2", pack(1, 0, 0, 0, 1, 0, 2'd2, 2'd1));
    applyStimulus(1'b0, 3'b000, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput("abort_idle", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    checkOutput("abort_no_done", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    runOp(F3_ENC, 2'd0, 2'd1, 2'd2, 2'd3, "post_abort");

    // A START raised mid-round must neither disturb nor queue behind the running operation.
    applyStimulus(1'b1, F3_ENC, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    @(negedge clk);
    checkOutput("busy_round0", pack(1, 0, 0, 0, 1, 0, 2'd0, 2'd0));
    applyStimulus(1'b1, F3_DEC, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput("busy_round1", pack(1, 0, 0, 0, 1, 0, 2'd1, 2'd1));
    @(negedge clk);
    checkOutput("busy_round2", pack(1, 0, 0, 0, 1, 0, 2'd2, 2'd2));
    repeat (2) @(negedge clk);
    checkOutput("busy_finish", pack(1, 1, 0, 0, 0, 1, 2'd0, 2'd0));
    @(negedge clk);
    checkOutput("busy_idle", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    checkOutput("busy_no_requeue", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));

    // START and ABORT together in IDLE: START is dropped.
    applyStimulus(1'b1, F3_ENC, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput("start_abort_idle", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    checkOutput("start_abort_still", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));

    // Asynchronous reset mid-round clears outputs before the next clock edge.
    applyStimulus(1'b1, F3_DEC, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_round1", pack(1, 0, 0, 0, 1, 0, 2'd1, 2'd2));
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_async_reset", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    repeat (6) @(negedge clk);
    checkOutput("reset_no_done", pack(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));

    // enc, dec, illegal, post_abort and the busy-start op each give exactly one DONE.
    #1;
    vectors++;
    assert (done_seen === 5)
      else begin
        miscompares++;
        $error("[TB] FAIL done_count observed=%0d expected=5", done_seen);
      end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
